score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Downstream consumer of the per-round point-detect stage.
- Turns its `Point` level output into a saturating 2-digit BCD game score.
- Counts rounds, ends the game after NUM_ROUNDS rounds and keeps a high score across games.
- BCD outputs drive the board's 7-segment display decoders directly.

Parameters:
- NUM_ROUNDS, 10, number of rounds per game; legal range 1..15.
- SCORE_MAX_BCD, 8'h99, saturation value of the score (tens:ones).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous active-low reset
- point  input  1  level from point-detect stage; each 0->1 transition is worth one point
- round_done  input  1  one-cycle pulse from round sequencer at the end of a round
- game_start  input  1  one-cycle pulse from start-button conditioning
- score_ones  output  4  BCD ones digit of current score
- score_tens  output  4  BCD tens digit of current score
- high_ones  output  4  BCD ones digit of high score
- high_tens  output  4  BCD tens digit of high score
- round_cnt  output  4  completed rounds in the current game, binary
- game_over  output  1  high while in OVER state
- new_high  output  1  one-cycle pulse when the high score is replaced

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, internal point_q=0, state=IDLE. The high score is cleared only by reset.
- Edge detect: point_q registers point every cycle. point_rise = point & ~point_q. A level held high counts once.
- FSM states: IDLE, PLAY, OVER.
- IDLE:
  - score and round_cnt are held; point and round_done are ignored.
  - game_start -> PLAY; clear score and round_cnt on the same edge.
- PLAY:
  - point_rise -> score +1 in BCD; the new value is visible on the next cycle (1-cycle latency).
  - Ones digit wraps 9->0 with tens carry. At 99 the score holds at 99.
  - round_done with round_cnt < NUM_ROUNDS-1 -> round_cnt +1.
  - round_done with round_cnt == NUM_ROUNDS-1:
    - round_cnt becomes NUM_ROUNDS; go to OVER.
    - Compare final score against high score. If strictly greater, copy it to high and assert new_high for exactly that transition cycle +1, i.e. one clock wide, registered.
  - point_rise and round_done in the same cycle: the point counts first. The final score and the high-score comparison include it.
  - game_start in PLAY: restart. Score and round_cnt cleared, stay in PLAY, high unchanged, no new_high.
  - game_start together with point_rise or round_done: game_start wins; the other events are dropped.
- OVER:
  - game_over=1; point and round_done ignored; score and round_cnt frozen for display.
  - game_start -> PLAY with score and round_cnt cleared; game_over drops on the same edge.
- game_over is registered (decoded from state). new_high is 0 in every state except the single pulse described above.
- Reset mid-game: immediate return to IDLE with everything zeroed, including the high score.
- Arithmetic:
  - Score is BCD only; no binary-to-BCD conversion.
  - High-score comparison is a plain 8-bit unsigned compare of {tens,ones}, which is valid for BCD.
  - round_cnt never exceeds NUM_ROUNDS.

Decomposition:
- Shared package (game_pkg):
  - state encoding constants S_IDLE=2'd0, S_PLAY=2'd1, S_OVER=2'd2
  - BCD digit width 4
  - SCORE_MAX_BCD
  - default NUM_ROUNDS
- Sub-module bcd2_sat_inc: combinational 2-digit BCD incrementer with saturation at 99. Inputs tens/ones plus an enable; outputs next tens/ones.
- FSM, edge detect, round counter and high-score register stay in score_keeper.

Test Plan:
- Reset then game_start; point high for 5 cycles then low -> score 01 (single count), state PLAY, game_over=0.
- 12 separate point pulses (2 cycles high, 2 low) -> score_tens=1, score_ones=2 (ones wrap and carry checked at 9->10).
- 105 point pulses -> score saturates at 99; the 100th and later pulses leave 99.
- NUM_ROUNDS=10, score 07, 10 round_done pulses -> round_cnt=10, game_over=1, high=07, new_high high exactly 1 cycle. Second game scoring 05 -> high stays 07, no new_high. Third game scoring 07 -> no new_high (not strictly greater).
- Final round_done coincides with a point rise at score 07, high 07 -> score 08, high 08, new_high pulses.
- game_start mid-PLAY at score 04 / round 3 -> score 00, round 0, still PLAY. Async rst pulse mid-game with high 08 -> all outputs 0 within the same cycle, state IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game score keeper.
package game_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = 2 * DIGIT_W;
  localparam int unsigned ROUND_W = 4;

  localparam logic [SCORE_W-1:0] GAME_SCORE_MAX_BCD = 8'h99;
  localparam int unsigned        GAME_NUM_ROUNDS    = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

endpackage

// File: rtl/bcd2_sat_inc.sv
// Two-digit BCD incrementer that holds once the maximum value is reached.
module bcd2_sat_inc
  import game_pkg::*;
#(
  parameter logic [SCORE_W-1:0] MAX_BCD = GAME_SCORE_MAX_BCD
) (
  input  logic [DIGIT_W-1:0] tens_i,
  input  logic [DIGIT_W-1:0] ones_i,
  input  logic               en_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o
);

  logic at_max_c;

  assign at_max_c = ({tens_i, ones_i} >= MAX_BCD);

  always_comb begin
    tens_o = tens_i;
    ones_o = ones_i;
    if (en_i && !at_max_c) begin
      if (ones_i == DIGIT_W'(9)) begin
        ones_o = '0;
        tens_o = DIGIT_W'(tens_i + DIGIT_W'(1));
      end else begin
        ones_o = DIGIT_W'(ones_i + DIGIT_W'(1));
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: point edge counting in BCD, round counting and high score.
module score_keeper
  import game_pkg::*;
#(
  parameter int unsigned        NUM_ROUNDS    = GAME_NUM_ROUNDS,
  parameter logic [SCORE_W-1:0] SCORE_MAX_BCD = GAME_SCORE_MAX_BCD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               point,
  input  logic               round_done,
  input  logic               game_start,
  output logic [DIGIT_W-1:0] score_ones,
  output logic [DIGIT_W-1:0] score_tens,
  output logic [DIGIT_W-1:0] high_ones,
  output logic [DIGIT_W-1:0] high_tens,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               game_over,
  output logic               new_high
);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 point_q;
  logic                 game_over_q, game_over_d;
  logic                 new_high_q, new_high_d;
  logic                 point_rise_c;
  logic [SCORE_W-1:0]   score_inc_c;

  assign point_rise_c = point & ~point_q;

  bcd2_sat_inc #(
    .MAX_BCD (SCORE_MAX_BCD)
  ) u_inc (
    .tens_i (score_q[SCORE_W-1:DIGIT_W]),
    .ones_i (score_q[DIGIT_W-1:0]),
    .en_i   (point_rise_c),
    .tens_o (score_inc_c[SCORE_W-1:DIGIT_W]),
    .ones_o (score_inc_c[DIGIT_W-1:0])
  );

  // Next-state logic; the point is folded in before the final-round compare.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    round_d    = round_q;
    new_high_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (game_start) begin
          state_d = S_PLAY;
          score_d = '0;
          round_d = '0;
        end
      end
      S_PLAY: begin
        if (game_start) begin
          score_d = '0;
          round_d = '0;
        end else begin
          score_d = score_inc_c;
          if (round_done) begin
            if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
              round_d = ROUND_W'(NUM_ROUNDS);
              state_d = S_OVER;
              if (score_inc_c > high_q) begin
                high_d     = score_inc_c;
                new_high_d = 1'b1;
              end
            end else begin
              round_d = ROUND_W'(round_q + ROUND_W'(1));
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      high_q      <= '0;
      round_q     <= '0;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
      new_high_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      round_q     <= round_d;
      point_q     <= point;
      game_over_q <= game_over_d;
      new_high_q  <= new_high_d;
    end
  end

  assign score_tens = score_q[SCORE_W-1:DIGIT_W];
  assign score_ones = score_q[DIGIT_W-1:0];
  assign high_tens  = high_q[SCORE_W-1:DIGIT_W];
  assign high_ones  = high_q[DIGIT_W-1:0];
  assign round_cnt  = round_q;
  assign game_over  = game_over_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed game scenarios plus random play vs. a decimal model.
module tb_score_keeper;

  localparam int unsigned NR = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       point = 1'b0;
  logic       round_done = 1'b0;
  logic       game_start = 1'b0;
  logic [3:0] score_ones, score_tens, high_ones, high_tens, round_cnt;
  logic       game_over, new_high;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers for score/high, flags for game phase.
  int m_score = 0;
  int m_high  = 0;
  int m_rounds = 0;
  bit m_playing = 0;
  bit m_over = 0;
  bit m_new_high = 0;
  bit m_prev = 0;

  score_keeper #(.NUM_ROUNDS(NR), .SCORE_MAX_BCD(8'h99)) dut (
    .clk        (clk),
    .rst        (rst),
    .point      (point),
    .round_done (round_done),
    .game_start (game_start),
    .score_ones (score_ones),
    .score_tens (score_tens),
    .high_ones  (high_ones),
    .high_tens  (high_tens),
    .round_cnt  (round_cnt),
    .game_over  (game_over),
    .new_high   (new_high)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("score", {score_tens, score_ones}, to_bcd(m_score));
    chk("high", {high_tens, high_ones}, to_bcd(m_high));
    chk("round_cnt", 8'(round_cnt), 8'(m_rounds));
    chk("game_over", 8'(game_over), 8'(m_over));
    chk("new_high", 8'(new_high), 8'(m_new_high));
  endtask

  task automatic model_reset();
    m_score = 0; m_high = 0; m_rounds = 0;
    m_playing = 0; m_over = 0; m_new_high = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit p, input bit rd, input bit gs);
    bit rise;
    rise = p && !m_prev;
    m_prev = p;
    m_new_high = 0;
    if (gs && (m_playing || m_over || (!m_playing && !m_over))) begin
      m_score = 0; m_rounds = 0; m_playing = 1; m_over = 0;
    end else if (m_playing) begin
      if (rise && m_score < 99) m_score++;
      if (rd) begin
        if (m_rounds + 1 == NR) begin
          m_rounds = NR; m_playing = 0; m_over = 1;
          if (m_score > m_high) begin
            m_high = m_score; m_new_high = 1;
          end
        end else begin
          m_rounds++;
        end
      end
    end
  endtask

  task automatic step(input bit p, input bit rd, input bit gs);
    @(negedge clk);
    point = p; round_done = rd; game_start = gs;
    model_step(p, rd, gs);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0); step(1, 0, 0);
      step(0, 0, 0); step(0, 0, 0);
    end
  endtask

  task automatic rounds(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0);
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_score", {score_tens, score_ones}, 8'h00);
    chk("reset_high", {high_tens, high_ones}, 8'h00);
    chk("reset_flags", {2'b00, game_over, new_high, round_cnt}, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // IDLE ignores points and rounds
    step(1, 1, 0); step(0, 0, 0);
    chk("idle_ignore", {score_tens, score_ones}, 8'h00);

    // Held level counts once
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("hold_once", {score_tens, score_ones}, 8'h01);
    chk("hold_play", 8'(game_over), 8'h00);

    // Ones wrap with carry
    step(0, 0, 1);
    pulses(10);
    chk("carry_10", {score_tens, score_ones}, 8'h10);
    pulses(2);
    chk("score_12", {score_tens, score_ones}, 8'h12);

    // Saturation at 99
    step(0, 0, 1);
    pulses(99);
    chk("sat_99", {score_tens, score_ones}, 8'h99);
    pulses(6);
    chk("sat_hold", {score_tens, score_ones}, 8'h99);

    // First full game: score 07 sets high
    step(0, 0, 1);
    pulses(7);
    rounds(9);
    step(0, 1, 0);
    chk("g1_over", 8'(game_over), 8'h01);
    chk("g1_newhigh", 8'(new_high), 8'h01);
    chk("g1_high", {high_tens, high_ones}, 8'h07);
    chk("g1_rounds", 8'(round_cnt), 8'd10);
    step(1, 1, 0);
    chk("g1_pulse_end", 8'(new_high), 8'h00);
    chk("g1_frozen", {score_tens, score_ones}, 8'h07);
    step(0, 0, 0);

    // Lower and equal scores leave high alone
    step(0, 0, 1);
    pulses(5);
    rounds(10);
    chk("g2_high", {high_tens, high_ones}, 8'h07);
    chk("g2_no_new", 8'(new_high), 8'h00);
    step(0, 0, 1);
    pulses(7);
    rounds(10);
    chk("g3_equal", 8'(new_high), 8'h00);

    // Final round coinciding with a point rise
    step(0, 0, 1);
    pulses(7);
    rounds(9);
    step(1, 1, 0);
    chk("g4_score", {score_tens, score_ones}, 8'h08);
    chk("g4_high", {high_tens, high_ones}, 8'h08);
    chk("g4_newhigh", 8'(new_high), 8'h01);
    step(0, 0, 0);

    // Restart mid-play, including simultaneous events
    step(0, 0, 1);
    pulses(4);
    rounds(3);
    step(1, 1, 1);
    chk("restart_score", {score_tens, score_ones}, 8'h00);
    chk("restart_round", 8'(round_cnt), 8'h00);
    chk("restart_play", 8'(game_over), 8'h00);
    step(0, 0, 0);

    // Asynchronous reset mid-game
    pulses(3);
    step(1, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_score", {score_tens, score_ones}, 8'h00);
    chk("arst_high", {high_tens, high_ones}, 8'h00);
    chk("arst_flags", {2'b00, game_over, new_high, round_cnt}, 8'h00);
    @(negedge clk);
    point = 1'b0;
    rst = 1'b1;

    // Random play against the model
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
